tx_resp_sched: RTL and testbench
================================

# tx_resp_sched

Response scheduler between the system controller's result sources and the UART TX async FIFO write port. It captures single-cycle RF read results (one byte) and ALU results (two bytes), arbitrates between them round-robin, and writes bytes into the FIFO one at a time under FIFO_FULL backpressure. A multi-byte response is never interleaved with another.

## Interface
Parameters:
- DATA_WIDTH, 8, byte width; the ALU result is 2*DATA_WIDTH.
- RF_TAG, 8'hBB, header byte for RF responses; used only with RESP_TAG_EN.
- ALU_TAG, 8'hCC, header byte for ALU responses; used only with RESP_TAG_EN.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset, asynchronous, active-low.
- RF_RdData  in  DATA_WIDTH  RF read result.
- RF_RdData_VLD  in  1  one-cycle pulse; RF_RdData valid.
- ALU_OUT  in  2*DATA_WIDTH  ALU result.
- ALU_OUT_VLD  in  1  one-cycle pulse; ALU_OUT valid.
- FIFO_FULL  in  1  TX FIFO cannot accept a write this cycle.
- ERR_CLR  in  1  clears DROP_ERR.
- WR_DATA  out  DATA_WIDTH  FIFO write data.
- WR_INC  out  1  FIFO write strobe.
- RESP_BUSY  out  1  either holding buffer occupied; the controller stalls new commands.
- DROP_ERR  out  1  sticky; a response was lost.

## Operation
- One holding buffer per source, each one entry: a data register plus a valid flag.
- Capture:
  - A VLD pulse at an edge loads that source's buffer when it is empty, or when it is being freed at that same edge (free-and-fill).
  - Otherwise the response is dropped, the buffer is unchanged and DROP_ERR sets.
- FSM states: IDLE, TAG, B0, B1.
  - IDLE: if any buffer is valid, grant one source. The next state is TAG when RESP_TAG_EN is defined, else B0.
  - TAG -> B0.
  - B0: for RF -> IDLE and free the RF buffer; for ALU -> B1.
  - B1 (ALU only) -> IDLE and free the ALU buffer.
  - Every transition out of TAG, B0 or B1 requires a write in that cycle (WR_INC=1).
- Arbitration:
  - If only one buffer is valid, that source wins.
  - If both are valid, the priority pointer decides. The pointer flips to the non-granted source after each completed response.
  - The pointer resets to RF.
- Byte order: the ALU result is sent LSB (ALU_OUT[7:0]) in B0, then MSB in B1. The RF byte is sent in B0.
- WR_DATA:
  - TAG: RF_TAG or ALU_TAG.
  - B0, B1: the selected buffer byte.
  - IDLE: 0.
- WR_INC = (state is TAG, B0 or B1) AND NOT FIFO_FULL. This is combinational, so the FIFO never receives a write while it is full.
- RESP_BUSY = RF buffer valid OR ALU buffer valid.
- DROP_ERR:
  - Set by any drop.
  - Cleared by ERR_CLR.
  - When a set and a clear happen at the same edge, set wins.
- Reset values: state IDLE, both buffers invalid with data 0, pointer = RF, WR_DATA 0, WR_INC 0, RESP_BUSY 0, DROP_ERR 0.

## Timing
- A VLD pulse is captured at edge N. At edge N+1 the FSM leaves IDLE. If FIFO_FULL=0, WR_INC is high in cycle N+1..N+2 and the first byte is written at edge N+2.
- Each subsequent byte takes one cycle when FIFO_FULL=0.
  - RF response occupies the FIFO port for 1 cycle (2 with tag).
  - ALU response occupies it for 2 cycles (3 with tag).
- FSM returns to IDLE for at least one cycle between responses. Back-to-back throughput is therefore 1 RF response per 2 cycles.
- FIFO_FULL high in any send state: hold the state and WR_DATA, and keep WR_INC=0. The write resumes in the first cycle FIFO_FULL is low. There is no timeout.
- Both VLD pulses at the same edge with both buffers empty: both are captured. The pointer selects the first response and the other follows immediately after.
- RST low at any time, including mid-response: everything returns to reset values immediately. Pending and partially sent responses are discarded, with no FIFO write after reset.

## Configuration
- RESP_TAG_EN defined: TAG state is present, and each response is prefixed by RF_TAG or ALU_TAG.
- RESP_TAG_EN undefined: the TAG state is removed entirely (IDLE goes directly to B0), and RF_TAG/ALU_TAG are unused.

## Structure
- Shared package:
  - FSM state encoding (IDLE, TAG, B0, B1).
  - Source-select encoding (SRC_RF, SRC_ALU).
  - Default tag constants 8'hBB and 8'hCC.
- Sub-module resp_hold_buf, instantiated twice with width DATA_WIDTH and 2*DATA_WIDTH:
  - Holds one entry with a valid flag.
  - Inputs: load pulse and free pulse.
  - Outputs: data, valid, and a drop pulse (load while valid and not being freed).

## Test plan
- RF_RdData=8'h14 pulse, FIFO_FULL=0 -> single WR_INC two edges later with WR_DATA=8'h14 (tag build: 8'hBB then 8'h14). RESP_BUSY falls after the write.
- ALU_OUT=16'h1234 pulse -> consecutive writes 8'h34, 8'h12 (tag build: 8'hCC, 8'h34, 8'h12).
- Both pulses at the same edge after reset (RF=8'hAA, ALU=16'h0102) -> FIFO sequence AA, 02, 01. Repeat with the pointer at ALU -> 02, 01, AA.
- FIFO_FULL high for 5 cycles during ALU B1 -> WR_INC stays 0 for those cycles, WR_DATA holds 8'h12, and the write completes on the first low cycle.
- Second RF pulse while the RF buffer is pending and FIFO_FULL is high -> DROP_ERR=1, first byte still delivered. ERR_CLR -> DROP_ERR=0.
- RST low during ALU B1 -> WR_INC=0 immediately, no MSB write. After reset release: RESP_BUSY=0 and the next RF response is sent normally.

Source files
------------

// File: rtl/tx_resp_sched_pkg.sv
// Shared types and constants for the TX response scheduler.
// Optional feature macro used by the scheduler: RESP_TAG_EN.
package tx_resp_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TAG  = 2'd1,
    ST_B0   = 2'd2,
    ST_B1   = 2'd3
  } state_e;

  typedef enum logic {
    SRC_RF  = 1'b0,
    SRC_ALU = 1'b1
  } src_e;

  localparam logic [7:0] RF_TAG_DEFAULT  = 8'hBB;
  localparam logic [7:0] ALU_TAG_DEFAULT = 8'hCC;

  function automatic src_e other_src(input src_e s);
    return (s == SRC_RF) ? SRC_ALU : SRC_RF;
  endfunction

endpackage

// File: rtl/tx_resp_sched_hold_buf.sv
// One-entry holding buffer with valid flag; supports free-and-fill at the same
// edge and reports a drop pulse when a load finds it occupied.
module resp_hold_buf #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         free_i,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  output logic         drop_o
);

  logic [W-1:0] data_q;
  logic         valid_q;
  logic         accept;

  assign accept = load_i && (!valid_q || free_i);
  assign drop_o = load_i && valid_q && !free_i;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (accept) begin
        data_q  <= data_i;
        valid_q <= 1'b1;
      end else if (free_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/tx_resp_sched.sv
// Round-robin scheduler of RF (1 byte) and ALU (2 byte) responses into the TX
// FIFO write port. Define RESP_TAG_EN to prefix each response with a tag byte.
module tx_resp_sched
  import tx_resp_sched_pkg::*;
#(
  parameter int              DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] RF_TAG  = RF_TAG_DEFAULT,
  parameter logic [DATA_WIDTH-1:0] ALU_TAG = ALU_TAG_DEFAULT
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RF_RdData,
  input  logic                    RF_RdData_VLD,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VLD,
  input  logic                    FIFO_FULL,
  input  logic                    ERR_CLR,
  output logic [DATA_WIDTH-1:0]   WR_DATA,
  output logic                    WR_INC,
  output logic                    RESP_BUSY,
  output logic                    DROP_ERR
);

`ifdef RESP_TAG_EN
  localparam state_e FIRST_ST = ST_TAG;
`else
  localparam state_e FIRST_ST = ST_B0;
  logic unused_tags;
  assign unused_tags = ^{RF_TAG, ALU_TAG};
`endif

  state_e state_q, state_d;
  src_e   src_q, src_d;
  src_e   ptr_q, ptr_d;
  src_e   grant;
  logic   drop_err_q, drop_err_d;

  logic [DATA_WIDTH-1:0]   rf_data;
  logic [2*DATA_WIDTH-1:0] alu_data;
  logic rf_vld, alu_vld, rf_drop, alu_drop, rf_free, alu_free;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    wr_inc;

  resp_hold_buf #(.W(DATA_WIDTH)) u_rf_buf (
    .CLK     (CLK),
    .RST     (RST),
    .load_i  (RF_RdData_VLD),
    .data_i  (RF_RdData),
    .free_i  (rf_free),
    .data_o  (rf_data),
    .valid_o (rf_vld),
    .drop_o  (rf_drop)
  );

  resp_hold_buf #(.W(2*DATA_WIDTH)) u_alu_buf (
    .CLK     (CLK),
    .RST     (RST),
    .load_i  (ALU_OUT_VLD),
    .data_i  (ALU_OUT),
    .free_i  (alu_free),
    .data_o  (alu_data),
    .valid_o (alu_vld),
    .drop_o  (alu_drop)
  );

  // Pointer only matters when both buffers compete.
  assign grant = (rf_vld && alu_vld) ? ptr_q : (rf_vld ? SRC_RF : SRC_ALU);

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    ptr_d    = ptr_q;
    rf_free  = 1'b0;
    alu_free = 1'b0;
    wr_data  = '0;
    wr_inc   = (state_q != ST_IDLE) && !FIFO_FULL;

    case (state_q)
      ST_IDLE: begin
        if (rf_vld || alu_vld) begin
          src_d   = grant;
          state_d = FIRST_ST;
        end
      end
`ifdef RESP_TAG_EN
      ST_TAG: begin
        wr_data = (src_q == SRC_ALU) ? ALU_TAG : RF_TAG;
        if (wr_inc) state_d = ST_B0;
      end
`endif
      ST_B0: begin
        wr_data = (src_q == SRC_ALU) ? alu_data[DATA_WIDTH-1:0] : rf_data;
        if (wr_inc) begin
          if (src_q == SRC_ALU) begin
            state_d = ST_B1;
          end else begin
            state_d = ST_IDLE;
            rf_free = 1'b1;
            ptr_d   = other_src(src_q);
          end
        end
      end
      ST_B1: begin
        wr_data = alu_data[2*DATA_WIDTH-1:DATA_WIDTH];
        if (wr_inc) begin
          state_d  = ST_IDLE;
          alu_free = 1'b1;
          ptr_d    = other_src(src_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A new drop at the same edge as a clear keeps the flag set.
  assign drop_err_d = (rf_drop || alu_drop) ? 1'b1 :
                      (ERR_CLR ? 1'b0 : drop_err_q);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      src_q      <= SRC_RF;
      ptr_q      <= SRC_RF;
      drop_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      ptr_q      <= ptr_d;
      drop_err_q <= drop_err_d;
    end
  end

  assign WR_DATA   = wr_data;
  assign WR_INC    = wr_inc;
  assign RESP_BUSY = rf_vld || alu_vld;
  assign DROP_ERR  = drop_err_q;

endmodule

// File: tb/tb_tx_resp_sched.sv
// Directed self-checking bench for tx_resp_sched; tag bytes are expected only
// when RESP_TAG_EN is defined.
module tb_tx_resp_sched;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [7:0]  RF_RdData = '0;
  logic        RF_RdData_VLD = 1'b0;
  logic [15:0] ALU_OUT = '0;
  logic        ALU_OUT_VLD = 1'b0;
  logic        FIFO_FULL = 1'b0;
  logic        ERR_CLR = 1'b0;
  logic [7:0]  WR_DATA;
  logic        WR_INC;
  logic        RESP_BUSY;
  logic        DROP_ERR;

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  int wr_snap;

  tx_resp_sched dut (
    .CLK           (CLK),
    .RST           (RST),
    .RF_RdData     (RF_RdData),
    .RF_RdData_VLD (RF_RdData_VLD),
    .ALU_OUT       (ALU_OUT),
    .ALU_OUT_VLD   (ALU_OUT_VLD),
    .FIFO_FULL     (FIFO_FULL),
    .ERR_CLR       (ERR_CLR),
    .WR_DATA       (WR_DATA),
    .WR_INC        (WR_INC),
    .RESP_BUSY     (RESP_BUSY),
    .DROP_ERR      (DROP_ERR)
  );

  always #5 CLK = ~CLK;

  // Counts FIFO writes, sampled mid-cycle.
  always @(negedge CLK) if (WR_INC === 1'b1) wr_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_rf(input logic [7:0] d);
    RF_RdData = d;
    RF_RdData_VLD = 1'b1;
    tick();
    RF_RdData_VLD = 1'b0;
  endtask

  task automatic pulse_alu(input logic [15:0] d);
    ALU_OUT = d;
    ALU_OUT_VLD = 1'b1;
    tick();
    ALU_OUT_VLD = 1'b0;
  endtask

  task automatic pulse_both(input logic [7:0] r, input logic [15:0] a);
    RF_RdData = r;
    ALU_OUT = a;
    RF_RdData_VLD = 1'b1;
    ALU_OUT_VLD = 1'b1;
    tick();
    RF_RdData_VLD = 1'b0;
    ALU_OUT_VLD = 1'b0;
  endtask

  // Checks one write per cycle: optional tag, then LSB, then MSB for ALU.
  task automatic expect_resp(input string tag, input bit is_alu,
                             input logic [15:0] val, input bit stop_before_msb);
`ifdef RESP_TAG_EN
    check({tag, "_tag_inc"}, WR_INC, 1'b1);
    check({tag, "_tag"}, WR_DATA, is_alu ? 8'hCC : 8'hBB);
    tick();
`endif
    check({tag, "_b0_inc"}, WR_INC, 1'b1);
    check({tag, "_b0"}, WR_DATA, val[7:0]);
    tick();
    if (is_alu && !stop_before_msb) begin
      check({tag, "_b1_inc"}, WR_INC, 1'b1);
      check({tag, "_b1"}, WR_DATA, val[15:8]);
      tick();
    end
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_wr_data", WR_DATA, 8'h00);
    check("rst_wr_inc", WR_INC, 1'b0);
    check("rst_busy", RESP_BUSY, 1'b0);
    check("rst_drop", DROP_ERR, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
    tick();

    // Single RF response
    pulse_rf(8'h14);
    check("t1_busy", RESP_BUSY, 1'b1);
    check("t1_idle_inc", WR_INC, 1'b0);
    tick();
    expect_resp("t1", 1'b0, 16'h0014, 1'b0);
    check("t1_busy_end", RESP_BUSY, 1'b0);
    check("t1_inc_end", WR_INC, 1'b0);

    // Single ALU response, LSB first
    pulse_alu(16'h1234);
    tick();
    expect_resp("t2", 1'b1, 16'h1234, 1'b0);
    check("t2_busy_end", RESP_BUSY, 1'b0);

    // Simultaneous pulses after reset: pointer at RF
    RST = 1'b0;
    #2;
    RST = 1'b1;
    tick();
    pulse_both(8'hAA, 16'h0102);
    check("t3_busy", RESP_BUSY, 1'b1);
    tick();
    expect_resp("t3_rf", 1'b0, 16'h00AA, 1'b0);
    check("t3_gap_inc", WR_INC, 1'b0);
    check("t3_gap_busy", RESP_BUSY, 1'b1);
    tick();
    expect_resp("t3_alu", 1'b1, 16'h0102, 1'b0);
    check("t3_busy_end", RESP_BUSY, 1'b0);

    // Move pointer to ALU with a lone RF response, then compete again
    pulse_rf(8'h55);
    tick();
    expect_resp("t4_pre", 1'b0, 16'h0055, 1'b0);
    pulse_both(8'hAA, 16'h0102);
    tick();
    expect_resp("t4_alu", 1'b1, 16'h0102, 1'b0);
    check("t4_gap_inc", WR_INC, 1'b0);
    tick();
    expect_resp("t4_rf", 1'b0, 16'h00AA, 1'b0);
    check("t4_busy_end", RESP_BUSY, 1'b0);

    // FIFO_FULL for 5 cycles during ALU B1
    pulse_alu(16'h1234);
    tick();
    expect_resp("t5", 1'b1, 16'h1234, 1'b1);
    FIFO_FULL = 1'b1;
    #1;
    wr_snap = wr_cnt;
    for (int i = 0; i < 5; i++) begin
      check("t5_full_inc", WR_INC, 1'b0);
      check("t5_full_data", WR_DATA, 8'h12);
      tick();
    end
    check("t5_no_writes", wr_cnt, wr_snap);
    FIFO_FULL = 1'b0;
    #1;
    check("t5_resume_inc", WR_INC, 1'b1);
    check("t5_resume_data", WR_DATA, 8'h12);
    tick();
    check("t5_busy_end", RESP_BUSY, 1'b0);
    check("t5_one_write", wr_cnt, wr_snap + 1);

    // Drop while RF buffer pending under backpressure
    FIFO_FULL = 1'b1;
    pulse_rf(8'h77);
    check("t6_drop_pre", DROP_ERR, 1'b0);
    tick();
    pulse_rf(8'h88);
    check("t6_drop", DROP_ERR, 1'b1);
    check("t6_busy", RESP_BUSY, 1'b1);
    FIFO_FULL = 1'b0;
    #1;
    expect_resp("t6", 1'b0, 16'h0077, 1'b0);
    check("t6_busy_end", RESP_BUSY, 1'b0);
    check("t6_sticky", DROP_ERR, 1'b1);
    ERR_CLR = 1'b1;
    tick();
    ERR_CLR = 1'b0;
    check("t6_cleared", DROP_ERR, 1'b0);

    // Drop and clear at the same edge: set wins
    FIFO_FULL = 1'b1;
    pulse_rf(8'h66);
    tick();
    RF_RdData = 8'h99;
    RF_RdData_VLD = 1'b1;
    ERR_CLR = 1'b1;
    tick();
    RF_RdData_VLD = 1'b0;
    ERR_CLR = 1'b0;
    check("t7_set_wins", DROP_ERR, 1'b1);
    FIFO_FULL = 1'b0;
    #1;
    expect_resp("t7", 1'b0, 16'h0066, 1'b0);
    ERR_CLR = 1'b1;
    tick();
    ERR_CLR = 1'b0;
    check("t7_cleared", DROP_ERR, 1'b0);

    // Free-and-fill: new RF pulse on the edge that writes the RF byte
    pulse_rf(8'h21);
    tick();
`ifdef RESP_TAG_EN
    check("t9_tag", WR_DATA, 8'hBB);
    tick();
`endif
    check("t9_b0", WR_DATA, 8'h21);
    check("t9_b0_inc", WR_INC, 1'b1);
    RF_RdData = 8'h42;
    RF_RdData_VLD = 1'b1;
    tick();
    RF_RdData_VLD = 1'b0;
    check("t9_no_drop", DROP_ERR, 1'b0);
    check("t9_busy", RESP_BUSY, 1'b1);
    check("t9_gap_inc", WR_INC, 1'b0);
    tick();
    expect_resp("t9_refill", 1'b0, 16'h0042, 1'b0);
    check("t9_busy_end", RESP_BUSY, 1'b0);

    // Reset during ALU B1
    pulse_alu(16'h1234);
    tick();
    expect_resp("t8", 1'b1, 16'h1234, 1'b1);
    check("t8_b1_inc", WR_INC, 1'b1);
    wr_snap = wr_cnt;
    RST = 1'b0;
    #1;
    check("t8_rst_inc", WR_INC, 1'b0);
    check("t8_rst_data", WR_DATA, 8'h00);
    check("t8_rst_busy", RESP_BUSY, 1'b0);
    tick();
    tick();
    RST = 1'b1;
    tick();
    check("t8_no_msb", wr_cnt, wr_snap);
    check("t8_busy_after", RESP_BUSY, 1'b0);
    check("t8_idle_inc", WR_INC, 1'b0);
    pulse_rf(8'h3C);
    tick();
    expect_resp("t8_rf", 1'b0, 16'h003C, 1'b0);
    check("t8_busy_end", RESP_BUSY, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
